// File: rtl/d3s_frev_align_ctrl.sv
// rtl/d3s_frev_align_ctrl.sv - frev timestamp to WR time alignment and divider-start control
// Optional wait timeout enabled by defining D3S_FREV_ALIGN_TIMEOUT_EN.
module d3s_frev_align_ctrl #(
   parameter int G_TIMEOUT_CYCLES = 125000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic [31:0] adjust_ns_i,
   input  logic [31:0] frev_ts_tai_i,
   input  logic [31:0] frev_ts_nsec_i,
   input  logic        frev_ts_valid_i,
   output logic        frev_ts_ready_o,
   input  logic        tm_time_valid_i,
   input  logic [31:0] tm_tai_i,
   input  logic [27:0] tm_cycles_i,
   input  logic [3:0]  zc_i,
   output logic        sync_valid_o,
   output logic [3:0]  sync_sel_o,
   output logic        busy_o,
   output logic        late_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {S_IDLE, S_ADJUST, S_WAIT_MATCH, S_WAIT_ZC} state_t;

   localparam logic [31:0] NS_PER_SEC = 32'd1000000000;

   state_t      state_q, state_d;
   logic [31:0] ts_tai_q;
   logic [31:0] ts_ns_q;
   logic        first_q;
   logic        sync_valid_q;
   logic [3:0]  sync_sel_q, sel_d;
   logic        late_q;
   logic        emit, late_set;
   logic        accept, abort, is_late, is_match;
   logic [3:0]  zc_mask, zc_masked;
   logic [28:0] cycles_ext;

   // Lowest active subsample wins: earlier subsample means more phases to start.
   function automatic logic [3:0] sel_enc(input logic [3:0] z);
      if (z[0])      return 4'b1111;
      else if (z[1]) return 4'b1110;
      else if (z[2]) return 4'b1100;
      else           return 4'b1000;
   endfunction

   assign frev_ts_ready_o = (state_q == S_IDLE) && enable_i && tm_time_valid_i && !rst_i;
   assign accept          = frev_ts_valid_i && frev_ts_ready_o;
   assign abort           = !enable_i || !tm_time_valid_i;
   assign cycles_ext      = {1'b0, tm_cycles_i};
   assign is_match        = (ts_tai_q == tm_tai_i) && (ts_ns_q[31:3] == cycles_ext);
   assign is_late         = (ts_tai_q < tm_tai_i) ||
                            ((ts_tai_q == tm_tai_i) && (ts_ns_q[31:3] < cycles_ext));
   assign zc_masked       = zc_i & zc_mask;
   assign busy_o          = (state_q != S_IDLE);
   assign sync_valid_o    = sync_valid_q;
   assign sync_sel_o      = sync_sel_q;
   assign late_o          = late_q;

   // Subsamples that precede the target nanosecond inside the match cycle are ignored.
   always_comb begin
      zc_mask = 4'b0000;
      case (ts_ns_q[2:1])
         2'd0:    zc_mask = 4'b0111;
         2'd1:    zc_mask = 4'b0011;
         2'd2:    zc_mask = 4'b0001;
         default: zc_mask = 4'b0000;
      endcase
   end

`ifdef D3S_FREV_ALIGN_TIMEOUT_EN
   localparam int CNT_W = $clog2(G_TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             to_hit, to_set, timeout_q;

   assign to_hit    = (cnt_q == CNT_W'(G_TIMEOUT_CYCLES - 1));
   assign timeout_o = timeout_q;

   // Wait-cycle counter, zeroed while entering WAIT_MATCH.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= to_set;
         if (state_q == S_ADJUST)
            cnt_q <= '0;
         else if (state_q == S_WAIT_MATCH || state_q == S_WAIT_ZC)
            cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   assign timeout_o = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and pulse decisions; abort outranks late, emit, then timeout.
   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      sel_d    = sync_sel_q;
      late_set = 1'b0;
`ifdef D3S_FREV_ALIGN_TIMEOUT_EN
      to_set   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_ADJUST;
         end
         S_ADJUST: begin
            state_d = abort ? S_IDLE : S_WAIT_MATCH;
         end
         S_WAIT_MATCH: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (first_q && is_late) begin
               late_set = 1'b1;
               state_d  = S_IDLE;
            end else if (is_match && zc_masked != 4'b0000) begin
               emit    = 1'b1;
               sel_d   = sel_enc(zc_masked);
               state_d = S_IDLE;
`ifdef D3S_FREV_ALIGN_TIMEOUT_EN
            end else if (to_hit) begin
               to_set  = 1'b1;
               state_d = S_IDLE;
`endif
            end else if (is_match) begin
               state_d = S_WAIT_ZC;
            end
         end
         S_WAIT_ZC: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (zc_i != 4'b0000) begin
               emit    = 1'b1;
               sel_d   = sel_enc(zc_i);
               state_d = S_IDLE;
`ifdef D3S_FREV_ALIGN_TIMEOUT_EN
            end else if (to_hit) begin
               to_set  = 1'b1;
               state_d = S_IDLE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Timestamp capture with adjust offset, then second wrap in the ADJUST cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_tai_q <= '0;
         ts_ns_q  <= '0;
         first_q  <= 1'b0;
      end else begin
         first_q <= (state_q == S_ADJUST);
         if (accept) begin
            ts_tai_q <= frev_ts_tai_i;
            ts_ns_q  <= frev_ts_nsec_i + adjust_ns_i;
         end else if (state_q == S_ADJUST && ts_ns_q >= NS_PER_SEC) begin
            ts_tai_q <= ts_tai_q + 32'd1;
            ts_ns_q  <= ts_ns_q - NS_PER_SEC;
         end
      end
   end

   // Registered output pulses; the start-phase select holds between emits.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_valid_q <= 1'b0;
         sync_sel_q   <= 4'b0000;
         late_q       <= 1'b0;
      end else begin
         sync_valid_q <= emit;
         sync_sel_q   <= sel_d;
         late_q       <= late_set;
      end
   end

endmodule

// File: tb/tb_d3s_frev_align_ctrl.sv
// tb/tb_d3s_frev_align_ctrl.sv - self-checking bench for d3s_frev_align_ctrl
module tb_d3s_frev_align_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        enable_i;
   logic [31:0] adjust_ns_i;
   logic [31:0] frev_ts_tai_i;
   logic [31:0] frev_ts_nsec_i;
   logic        frev_ts_valid_i;
   logic        frev_ts_ready_o;
   logic        tm_time_valid_i;
   logic [31:0] tm_tai_i;
   logic [27:0] tm_cycles_i;
   logic [3:0]  zc_i;
   logic        sync_valid_o;
   logic [3:0]  sync_sel_o;
   logic        busy_o;
   logic        late_o;
   logic        timeout_o;

   int n_vec = 0;
   int n_err = 0;

   d3s_frev_align_ctrl #(.G_TIMEOUT_CYCLES(100)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .adjust_ns_i(adjust_ns_i),
      .frev_ts_tai_i(frev_ts_tai_i), .frev_ts_nsec_i(frev_ts_nsec_i),
      .frev_ts_valid_i(frev_ts_valid_i), .frev_ts_ready_o(frev_ts_ready_o),
      .tm_time_valid_i(tm_time_valid_i), .tm_tai_i(tm_tai_i), .tm_cycles_i(tm_cycles_i),
      .zc_i(zc_i), .sync_valid_o(sync_valid_o), .sync_sel_o(sync_sel_o),
      .busy_o(busy_o), .late_o(late_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #300000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: apply the offset, wrap the second once if needed.
   task automatic model_adj(input logic [31:0] tai, input logic [31:0] nsec, input logic [31:0] adj,
                            output logic [31:0] etai, output logic [31:0] ens);
      logic [31:0] s;
      s = nsec + adj;
      if (s >= 32'd1000000000) begin
         etai = tai + 1;
         ens  = s - 32'd1000000000;
      end else begin
         etai = tai;
         ens  = s;
      end
   endtask

   // Subsample j of the match cycle is eligible when it lies after the target phase.
   function automatic logic [3:0] model_win(input logic [31:0] ns);
      logic [3:0] m;
      int ph;
      ph = int'(ns % 8) / 2;
      for (int j = 0; j < 4; j++) m[j] = (j < 3 - ph);
      return m;
   endfunction

   // Thermometer: phases from the earliest active subsample up to 3 are started.
   function automatic logic [3:0] model_sel(input logic [3:0] z);
      int k;
      int v;
      k = 3;
      for (int j = 3; j >= 0; j--) if (z[j]) k = j;
      v = ((1 << (4 - k)) - 1) << k;
      return v[3:0];
   endfunction

   // Offer a timestamp in IDLE; returns just after the edge entering WAIT_MATCH.
   task automatic offer(input logic [31:0] tai, input logic [31:0] nsec, input logic [31:0] adj,
                        input logic [31:0] t_tai, input logic [27:0] t_cyc);
      @(posedge clk_i); #1;
      frev_ts_tai_i   = tai;
      frev_ts_nsec_i  = nsec;
      adjust_ns_i     = adj;
      tm_tai_i        = t_tai;
      tm_cycles_i     = t_cyc;
      zc_i            = 4'b0000;
      frev_ts_valid_i = 1'b1;
      @(negedge clk_i);
      chk("ready_idle", 32'(frev_ts_ready_o), 32'd1);
      @(posedge clk_i); #1;
      frev_ts_valid_i = 1'b0;
      @(negedge clk_i);
      chk("busy_adjust", 32'(busy_o), 32'd1);
      @(posedge clk_i); #1;
   endtask

   task automatic align(input logic [31:0] tai, input logic [31:0] nsec, input logic [31:0] adj,
                        input int lead_in, input logic [3:0] zc_m, input int gap,
                        input logic [3:0] zc_l);
      logic [31:0] etai, ens, target;
      logic [3:0]  m, exp_sel;
      int          lead;
      model_adj(tai, nsec, adj, etai, ens);
      target = ens >> 3;
      lead   = (lead_in > int'(target)) ? int'(target) : lead_in;
      m      = zc_m & model_win(ens);
      exp_sel = (m != 4'b0000) ? model_sel(m) : model_sel(zc_l);
      offer(tai, nsec, adj, etai, 28'(target - 32'(lead)));
      frev_ts_valid_i = 1'b1;
      if (lead == 0) zc_i = zc_m;
      @(negedge clk_i);
      chk("ready_while_busy", 32'(frev_ts_ready_o), 32'd0);
      frev_ts_valid_i = 1'b0;
      for (int i = 1; i <= lead; i++) begin
         @(posedge clk_i); #1;
         tm_cycles_i = tm_cycles_i + 28'd1;
         if (i == lead) zc_i = zc_m;
      end
      @(posedge clk_i); #1;
      if (m != 4'b0000) begin
         zc_i = 4'b0000;
      end else begin
         zc_i = (gap == 1) ? zc_l : 4'b0000;
         @(negedge clk_i);
         chk("no_sync_at_match", 32'(sync_valid_o), 32'd0);
         chk("busy_wait_zc", 32'(busy_o), 32'd1);
         for (int j = 2; j <= gap; j++) begin
            @(posedge clk_i); #1;
            zc_i = (j == gap) ? zc_l : 4'b0000;
         end
         @(posedge clk_i); #1;
         zc_i = 4'b0000;
      end
      @(negedge clk_i);
      chk("sync_valid", 32'(sync_valid_o), 32'd1);
      chk("sync_sel", 32'(sync_sel_o), 32'(exp_sel));
      chk("busy_after_sync", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      chk("sync_one_cycle", 32'(sync_valid_o), 32'd0);
      chk("sync_sel_hold", 32'(sync_sel_o), 32'(exp_sel));
   endtask

   task automatic late_case(input logic [31:0] tai, input logic [31:0] nsec, input logic [31:0] adj,
                            input logic [31:0] t_tai, input logic [27:0] t_cyc);
      logic [31:0] etai, ens;
      logic        exp_late;
      model_adj(tai, nsec, adj, etai, ens);
      exp_late = (etai < t_tai) || (etai == t_tai && (ens >> 3) < {4'd0, t_cyc});
      offer(tai, nsec, adj, t_tai, t_cyc);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("late_pulse", 32'(late_o), 32'(exp_late));
      chk("late_no_sync", 32'(sync_valid_o), 32'd0);
      chk("late_ready", 32'(frev_ts_ready_o), 32'd1);
      @(negedge clk_i);
      chk("late_one_cycle", 32'(late_o), 32'd0);
   endtask

   initial begin
      int first_to;
      logic [31:0] r_tai, r_ns, r_adj, etai, ens;
      rst_i = 1'b1; enable_i = 1'b1; tm_time_valid_i = 1'b1; frev_ts_valid_i = 1'b1;
      adjust_ns_i = '0; frev_ts_tai_i = '0; frev_ts_nsec_i = '0;
      tm_tai_i = '0; tm_cycles_i = '0; zc_i = 4'b0000;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ready", 32'(frev_ts_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_sync_valid", 32'(sync_valid_o), 32'd0);
      chk("rst_sync_sel", 32'(sync_sel_o), 32'd0);
      chk("rst_late", 32'(late_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0; frev_ts_valid_i = 1'b0;

      // Directed matches: masked hit, masked miss then WAIT_ZC, second wrap.
      align(32'd10, 32'd1000, 32'd5000, 3, 4'b0010, 1, 4'b0000);
      align(32'd20, 32'd4004, 32'd0, 2, 4'b0100, 2, 4'b0001);
      align(32'd30, 32'd999998000, 32'd5000, 2, 4'b0001, 1, 4'b0000);
      align(32'd31, 32'd7, 32'd0, 0, 4'b1111, 1, 4'b1000);

      // Late by seconds, then late by cycles within the same second.
      late_case(32'd5, 32'd1000, 32'd0, 32'd6, 28'd0);
      late_case(32'd7, 32'd8000, 32'd0, 32'd7, 28'd1001);

      // Disable while in WAIT_MATCH: no pulses, controller idles.
      model_adj(32'd40, 32'd80000, 32'd0, etai, ens);
      offer(32'd40, 32'd80000, 32'd0, etai, 28'((ens >> 3) - 10));
      @(posedge clk_i); #1;
      enable_i = 1'b0;
      @(posedge clk_i); #1;
      enable_i = 1'b1; tm_cycles_i = 28'(ens >> 3); zc_i = 4'b1111;
      @(negedge clk_i);
      chk("abort_busy", 32'(busy_o), 32'd0);
      chk("abort_late", 32'(late_o), 32'd0);
      @(negedge clk_i);
      chk("abort_no_sync", 32'(sync_valid_o), 32'd0);
      zc_i = 4'b0000;

      // Time invalid while in WAIT_ZC.
      model_adj(32'd41, 32'd6, 32'd0, etai, ens);
      offer(32'd41, 32'd6, 32'd0, etai, 28'(ens >> 3));
      @(posedge clk_i); #1;
      tm_time_valid_i = 1'b0;
      @(negedge clk_i);
      chk("tv_wait_zc_busy", 32'(busy_o), 32'd1);
      @(posedge clk_i); #1;
      tm_time_valid_i = 1'b1; zc_i = 4'b0001;
      @(negedge clk_i);
      chk("tv_abort_busy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      chk("tv_abort_no_sync", 32'(sync_valid_o), 32'd0);
      zc_i = 4'b0000;

      // Reset while in WAIT_ZC with a crossing present at the reset edge.
      model_adj(32'd42, 32'd6, 32'd0, etai, ens);
      offer(32'd42, 32'd6, 32'd0, etai, 28'(ens >> 3));
      @(posedge clk_i); #1;
      rst_i = 1'b1; zc_i = 4'b0001;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rstzc_sync_sel", 32'(sync_sel_o), 32'd0);
      chk("rstzc_sync_valid", 32'(sync_valid_o), 32'd0);
      chk("rstzc_busy", 32'(busy_o), 32'd0);
      chk("rstzc_ready", 32'(frev_ts_ready_o), 32'd0);
      chk("rstzc_late", 32'(late_o), 32'd0);
      chk("rstzc_timeout", 32'(timeout_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_no_sync", 32'(sync_valid_o), 32'd0);
      @(negedge clk_i);
      chk("post_rst_no_sync2", 32'(sync_valid_o), 32'd0);
      zc_i = 4'b0000;

      // Randomized matches and late offers.
      for (int t = 0; t < 16; t++) begin
         r_tai = $urandom_range(1000, 1);
         r_ns  = $urandom_range(999999999, 0);
         r_adj = $urandom_range(999999999, 0);
         align(r_tai, r_ns, r_adj, $urandom_range(4, 0), 4'($urandom_range(15, 0)),
               $urandom_range(3, 1), 4'($urandom_range(15, 1)));
      end
      for (int t = 0; t < 6; t++) begin
         r_tai = $urandom_range(1000, 1);
         r_ns  = $urandom_range(999999000, 0);
         r_adj = $urandom_range(500, 0);
         model_adj(r_tai, r_ns, r_adj, etai, ens);
         if (t[0]) late_case(r_tai, r_ns, r_adj, etai + 1, 28'($urandom_range(1000, 0)));
         else      late_case(r_tai, r_ns, r_adj, etai, 28'((ens >> 3) + $urandom_range(5, 1)));
      end

      // Match with no crossing held: timeout after 100 wait cycles, or waits forever.
      model_adj(32'd50, 32'd6, 32'd0, etai, ens);
      offer(32'd50, 32'd6, 32'd0, etai, 28'(ens >> 3));
      first_to = -1;
      for (int n = 0; n <= 150; n++) begin
         @(negedge clk_i);
         if (timeout_o && first_to < 0) first_to = n;
      end
`ifdef D3S_FREV_ALIGN_TIMEOUT_EN
      chk("timeout_cycle", 32'(first_to), 32'd100);
      chk("timeout_busy", 32'(busy_o), 32'd0);
`else
      chk("no_timeout", 32'(first_to), 32'hffffffff);
      chk("still_wait_zc", 32'(busy_o), 32'd1);
`endif
      @(posedge clk_i); #1;
      enable_i = 1'b0;
      @(posedge clk_i); #1;
      enable_i = 1'b1;
      @(negedge clk_i);
      chk("final_idle", 32'(busy_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/d3s_frev_align_ctrl.md
D3S_FREV_ALIGN_CTRL -- requirements
Module: d3s_frev_align_ctrl

Interface
REQ-001 SHALL have parameter G_TIMEOUT_CYCLES, default 125000000, meaning max cycles spent waiting for match plus zero-crossing (1 s at 8 ns/cycle).
REQ-002 SHALL have ports:
- clk_i  in  1  WR reference clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  arms the controller; low forces IDLE.
- adjust_ns_i  in  32  unsigned offset added to the frev timestamp nsec field.
- frev_ts_tai_i  in  32  frev timestamp, TAI seconds.
- frev_ts_nsec_i  in  32  frev timestamp, nanoseconds (0..999999999).
- frev_ts_valid_i  in  1  timestamp offer.
- frev_ts_ready_o  out  1  timestamp accept.
- tm_time_valid_i  in  1  local WR time valid.
- tm_tai_i  in  32  local TAI seconds.
- tm_cycles_i  in  28  local 8 ns cycle count.
- zc_i  in  4  per-subsample zero-crossing flags from the upsampled phase datapath.
- sync_valid_o  out  1  one-cycle divider-start pulse.
- sync_sel_o  out  4  thermometer start-phase select.
- busy_o  out  1  high in any state other than IDLE.
- late_o  out  1  one-cycle pulse: timestamp already in the past.
- timeout_o  out  1  one-cycle pulse: wait expired.

Function
REQ-003 SHALL implement states IDLE, ADJUST, WAIT_MATCH and WAIT_ZC.
REQ-004 frev_ts_ready_o SHALL be 1 only in IDLE with enable_i=1 and tm_time_valid_i=1; on valid&&ready, SHALL register the timestamp and go to ADJUST.
REQ-005 The adjusted value SHALL be computed as ns_adj = nsec + adjust_ns_i (32-bit unsigned).
REQ-006 If ns_adj >= 1000000000, SHALL store tai+1 and ns_adj-1000000000; otherwise SHALL store tai and ns_adj unchanged.
REQ-007 ADJUST SHALL last exactly one cycle, then go to WAIT_MATCH.
REQ-008 On the first WAIT_MATCH cycle, if (tai, ns[31:3]) is lexicographically less than (tm_tai_i, tm_cycles_i), SHALL pulse late_o and return to IDLE.
REQ-009 Match SHALL be defined as tai==tm_tai_i and ns[31:3]==tm_cycles_i.
REQ-010 In the match cycle, zc_i SHALL be masked by ns[2:0]:
- 0 or 1: mask 0111.
- 2 or 3: mask 0011.
- 4 or 5: mask 0001.
- 6 or 7: mask 0000.
REQ-011 If the masked zc is nonzero, SHALL emit sync in the match cycle; otherwise SHALL go to WAIT_ZC.
REQ-012 In WAIT_ZC, SHALL emit sync on the first cycle with zc_i nonzero (unmasked).
REQ-013 sync_sel_o encoding SHALL use priority on the (masked) zc:
- bit0 set: 1111.
- else bit1 set: 1110.
- else bit2 set: 1100.
- else: 1000.
REQ-014 Emit SHALL be registered: sync_valid_o=1 for exactly one cycle after the deciding cycle; sync_sel_o updates in that same cycle and holds until the next emit; FSM returns to IDLE.
REQ-015 enable_i=0 or tm_time_valid_i=0 in any non-IDLE state SHALL force IDLE next cycle with no pulse.
REQ-016 Offers while busy SHALL not be accepted and SHALL not be buffered.
REQ-017 Late check SHALL take priority over match when both apply in the same cycle.
REQ-018 The timeout counter SHALL clear on entry to WAIT_MATCH and count in WAIT_MATCH and WAIT_ZC.
REQ-019 Priority in one cycle SHALL be: disable/time-invalid, then emit, then timeout.

Reset
REQ-020 While rst_i=1 at a clock edge, SHALL enter IDLE, clear the counter and stored timestamp, and drive frev_ts_ready_o=0, sync_valid_o=0, sync_sel_o=0000, busy_o=0, late_o=0, timeout_o=0.
REQ-021 Reset mid-operation SHALL abort with no pending pulse emitted after release.

Configuration
REQ-022 With D3S_FREV_ALIGN_TIMEOUT_EN defined, when the counter reaches G_TIMEOUT_CYCLES the block SHALL pulse timeout_o and return to IDLE.
REQ-023 Without D3S_FREV_ALIGN_TIMEOUT_EN, the counter SHALL be absent, timeout_o SHALL be constant 0, and the wait SHALL be unbounded.

Verification
REQ-024 Match with masked zc: ts tai=10 nsec=1000, adjust=5000; match at tm_tai=10, cycles=750, zc=0010 -> sync_valid_o pulse, sync_sel_o=1110, busy_o low next cycle.
REQ-025 Masked zc then WAIT_ZC: nsec=4004 (ns[2:0]=4 after adjust=0), zc=0100 at match -> no sync; zc=0001 two cycles later -> sync_sel_o=1111.
REQ-026 Second wrap: nsec=999998000, adjust=5000 -> stored tai+1, ns=3000; match at cycles=375.
REQ-027 Late timestamp: ts tai=5 while tm_tai=6 -> late_o single pulse, no sync, ready high again 1 cycle later.
REQ-028 Timeout (macro on, G_TIMEOUT_CYCLES=100): match with zc=0 held -> timeout_o at cycle 100; macro off -> stays in WAIT_ZC.
REQ-029 Abort and reset: enable_i low in WAIT_MATCH -> IDLE, no pulses; rst_i=1 in WAIT_ZC -> all outputs 0, sync_sel_o=0000.
